// File: rtl/solid_map_loader_pkg.sv
// Shared types and constants for the solid-map loader: room geometry,
// loader FSM state encoding and the sprite-flag helper used by the flag ROM.
package solid_map_loader_pkg;

   localparam int ROOM_TILES  = 16;
   localparam int TILE_PX     = 8;
   localparam int MAP_W_TILES = 128;

   typedef enum logic [2:0] {
      LD_IDLE  = 3'd0,
      LD_FETCH = 3'd1,
      LD_WAIT  = 3'd2,
      LD_WRITE = 3'd3,
      LD_DONE  = 3'd4
   } loader_state;

   // Sprite-flag table: ids 0x10..0x3F are wall tiles and 0xFF is the
   // boundary tile; both carry the solid flag in bit 0. The upper bits
   // carry the id's own attribute bits through unchanged.
   function automatic logic [7:0] sprite_flags(input logic [7:0] i_id);
      logic [7:0] w_f;
      w_f = {i_id[7:1], 1'b0};
      case (i_id[7:4])
         4'h1, 4'h2, 4'h3: w_f = {i_id[7:1], 1'b1};
         4'hF:             w_f = (i_id == 8'hFF) ? 8'hFF : {i_id[7:1], 1'b0};
         default:          w_f = {i_id[7:1], 1'b0};
      endcase
      return w_f;
   endfunction

endpackage

// File: rtl/solid_map_loader_tile_flag_rom.sv
// Combinational tile-id to flag-byte lookup, backed by the sprite-flag table.
module tile_flag_rom
   import solid_map_loader_pkg::*;
(
   input  logic [7:0] i_tile_id,
   output logic [7:0] o_flags
);

   logic [7:0] w_flags;

   // Table lookup; pure combinational so the loader can sample it on the
   // same cycle the ROM data becomes valid.
   always_comb begin
      w_flags = 8'h00;
      w_flags = sprite_flags(i_tile_id);
   end

   assign o_flags = w_flags;

endmodule

// File: rtl/solid_map_loader.sv
// Solid-map writer: on a room load, walks the room's 16x16 tiles in
// row-major order, fetches each tile id from the level ROM, looks up its
// solid flag and writes eight 8-pixel row segments per tile.
module solid_map_loader
   import solid_map_loader_pkg::*;
#(
   parameter int ROM_LATENCY = 1,
   parameter int FLAG_BIT    = 0
)
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic [4:0]  i_room,
   output logic        o_busy,
   output logic        o_done,
   output logic [12:0] o_rom_addr,
   input  logic [7:0]  i_rom_data,
   output logic        o_wr_en,
   output logic [6:0]  o_wr_x,
   output logic [6:0]  o_wr_y,
   output logic [7:0]  o_wr_bits
);

   // Last value of the WAIT counter: data is valid ROM_LATENCY cycles after
   // the address appears in FETCH, i.e. on WAIT cycle ROM_LATENCY-1.
   localparam logic [1:0] LAT_LAST  = 2'(ROM_LATENCY - 1);
   localparam logic [3:0] TILE_LAST = 4'(ROOM_TILES - 1);
   localparam logic [7:0] FLAG_MASK = 8'(8'h01 << FLAG_BIT);

   loader_state r_state;
   logic [4:0]  r_room;
   logic [3:0]  r_tx;
   logic [3:0]  r_ty;
   logic [2:0]  r_r;
   logic [1:0]  r_lat;
   logic        r_busy;
   logic        r_done;
   logic [12:0] r_rom_addr;
   logic        r_wr_en;
   logic [6:0]  r_wr_x;
   logic [6:0]  r_wr_y;
   logic [7:0]  r_wr_bits;

   logic [7:0]  w_flags;
   logic        w_solid;
   logic [3:0]  w_tx_next;
   logic [3:0]  w_ty_next;
   logic        w_last_tile;
   logic        w_lat_last;

   tile_flag_rom u_flag_rom (
      .i_tile_id (i_rom_data),
      .o_flags   (w_flags)
   );

   // Next-tile arithmetic and end-of-scan / end-of-wait detection.
   always_comb begin
      w_solid     = |(w_flags & FLAG_MASK);
      w_tx_next   = r_tx + 4'd1;
      w_ty_next   = (r_tx == TILE_LAST) ? (r_ty + 4'd1) : r_ty;
      w_last_tile = (r_tx == TILE_LAST) && (r_ty == TILE_LAST);
      w_lat_last  = (r_lat == LAT_LAST);
   end

   // Loader FSM with registered outputs: every output is set on the edge
   // that enters the state in which it must be visible.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= LD_IDLE;
         r_room     <= 5'd0;
         r_tx       <= 4'd0;
         r_ty       <= 4'd0;
         r_r        <= 3'd0;
         r_lat      <= 2'd0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_rom_addr <= 13'd0;
         r_wr_en    <= 1'b0;
         r_wr_x     <= 7'd0;
         r_wr_y     <= 7'd0;
         r_wr_bits  <= 8'd0;
      end else begin
         case (r_state)
            LD_IDLE: begin
               r_done <= 1'b0;
               if (i_start) begin
                  r_state    <= LD_FETCH;
                  r_room     <= i_room;
                  r_tx       <= 4'd0;
                  r_ty       <= 4'd0;
                  r_r        <= 3'd0;
                  r_busy     <= 1'b1;
                  r_rom_addr <= {i_room[4:3], 4'd0, i_room[2:0], 4'd0};
               end else begin
                  r_state <= LD_IDLE;
               end
            end
            LD_FETCH: begin
               r_state <= LD_WAIT;
               r_lat   <= 2'd0;
            end
            LD_WAIT: begin
               if (w_lat_last) begin
                  r_state   <= LD_WRITE;
                  r_r       <= 3'd0;
                  r_wr_en   <= 1'b1;
                  r_wr_bits <= w_solid ? 8'hFF : 8'h00;
                  r_wr_x    <= {r_tx, 3'b000};
                  r_wr_y    <= {r_ty, 3'b000};
               end else begin
                  r_lat <= r_lat + 2'd1;
               end
            end
            LD_WRITE: begin
               if (r_r == 3'd7) begin
                  r_wr_en   <= 1'b0;
                  r_wr_bits <= 8'h00;
                  if (w_last_tile) begin
                     r_state <= LD_DONE;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state    <= LD_FETCH;
                     r_tx       <= w_tx_next;
                     r_ty       <= w_ty_next;
                     r_rom_addr <= {r_room[4:3], w_ty_next, r_room[2:0], w_tx_next};
                  end
               end else begin
                  r_r    <= r_r + 3'd1;
                  r_wr_y <= {r_ty, r_r + 3'd1};
               end
            end
            LD_DONE: begin
               r_state <= LD_IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state   <= LD_IDLE;
               r_busy    <= 1'b0;
               r_done    <= 1'b0;
               r_wr_en   <= 1'b0;
               r_wr_bits <= 8'h00;
            end
         endcase
      end
   end

   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_rom_addr = r_rom_addr;
   assign o_wr_en    = r_wr_en;
   assign o_wr_x     = r_wr_x;
   assign o_wr_y     = r_wr_y;
   assign o_wr_bits  = r_wr_bits;

endmodule

// File: tb/tb_solid_map_loader.sv
// Scoreboard bench for solid_map_loader: instance 0 at ROM latency 1,
// instance 1 at ROM latency 3. Stimulus pushes the full expected write
// sequence (with exact cycle numbers) and the done pulse; a monitor pops
// and compares whenever a DUT writes or signals done.
module tb_solid_map_loader;

   typedef struct {
      int inst;
      bit is_done;
      int cyc;
      int x;
      int y;
      logic [7:0] bits;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [1:0] st = 2'b00;
   logic [4:0] room_in = 5'd0;
   logic [1:0] busy_o, done_o, wen;
   logic [1:0][12:0] raddr;
   logic [1:0][7:0] wb;
   logic [1:0][6:0] wx, wy;
   logic [7:0] rdata0, rdata1, p1, p2;

   int cyc = 0;
   int n_vec = 0;
   int n_fail = 0;
   int rom_mode = 0;
   int ff_cnt = 0;
   exp_t sb_q[$];
   bit map_q [128][128];

   always #5 clk = ~clk;

   solid_map_loader #(.ROM_LATENCY(1), .FLAG_BIT(0)) u_dut0 (
      .i_clk(clk), .i_rst(rst), .i_start(st[0]), .i_room(room_in),
      .o_busy(busy_o[0]), .o_done(done_o[0]), .o_rom_addr(raddr[0]),
      .i_rom_data(rdata0), .o_wr_en(wen[0]), .o_wr_x(wx[0]),
      .o_wr_y(wy[0]), .o_wr_bits(wb[0]));

   solid_map_loader #(.ROM_LATENCY(3), .FLAG_BIT(0)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_start(st[1]), .i_room(room_in),
      .o_busy(busy_o[1]), .o_done(done_o[1]), .o_rom_addr(raddr[1]),
      .i_rom_data(rdata1), .o_wr_en(wen[1]), .o_wr_x(wx[1]),
      .o_wr_y(wy[1]), .o_wr_bits(wb[1]));

   // Level tile map contents for each test mode.
   function automatic logic [7:0] tile_id(input int mode, input logic [12:0] a);
      if (mode == 1) return (a == 13'h0153) ? 8'h20 : 8'h42;
      if (mode == 2) return 8'(a[7:0] * 8'd29) ^ {3'b000, a[12:8]};
      return 8'h00;
   endfunction

   // Solid tiles: wall ids 0x10..0x3F and the boundary id 0xFF.
   function automatic bit solid_of(input logic [7:0] id);
      return ((id >= 8'h10) && (id <= 8'h3F)) || (id == 8'hFF);
   endfunction

   function automatic logic [12:0] tile_addr(input logic [4:0] rm, input int tx, input int ty);
      return 13'((rm[4:3] * 16 + ty) * 128 + rm[2:0] * 16 + tx);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // ROM models: one-cycle and three-cycle read latency.
   always @(posedge clk) rdata0 <= tile_id(rom_mode, raddr[0]);
   always @(posedge clk) begin
      p1 <= tile_id(rom_mode, raddr[1]);
      p2 <= p1;
      rdata1 <= p2;
   end

   // Monitor: pop and compare on every write or done pulse.
   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         if (!wen[i]) begin
            n_vec++;
            if (wb[i] != 8'h00) begin
               n_fail++;
               $display("FAIL idle_bits inst=%0d cyc=%0d got %h need 00", i, cyc, wb[i]);
            end
         end
         if (wen[i] || done_o[i]) begin
            n_vec++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_output inst=%0d cyc=%0d wr_en=%0b done=%0b", i, cyc, wen[i], done_o[i]);
            end else begin
               e = sb_q.pop_front();
               if (e.inst != i || e.is_done != done_o[i] || e.cyc != cyc ||
                   (e.is_done && busy_o[i] != 1'b0) ||
                   (!e.is_done && (busy_o[i] != 1'b1 || e.x != int'(wx[i]) ||
                                   e.y != int'(wy[i]) || e.bits != wb[i]))) begin
                  n_fail++;
                  $display("FAIL sb_compare got inst=%0d cyc=%0d done=%0b busy=%0b x=%0d y=%0d bits=%h need inst=%0d cyc=%0d done=%0b x=%0d y=%0d bits=%h",
                           i, cyc, done_o[i], busy_o[i], wx[i], wy[i], wb[i],
                           e.inst, e.cyc, e.is_done, e.x, e.y, e.bits);
               end
               if (wen[i]) begin
                  if (wx[i] == 7'd0 && wy[i] == 7'd0)
                     for (int yy = 0; yy < 128; yy++)
                        for (int xx = 0; xx < 128; xx++)
                           map_q[yy][xx] = ((xx ^ yy) & 1) != 0;
                  for (int k = 0; k < 8; k++) map_q[wy[i]][int'(wx[i]) + k] = wb[i][k];
                  if (wb[i] == 8'hFF) ff_cnt++;
               end
            end
         end
      end
   end

   task automatic push_expected(input int inst, input logic [4:0] rm, input int mode, input int s);
      int p, l;
      exp_t e;
      l = (inst == 1) ? 3 : 1;
      p = 9 + l;
      for (int ty = 0; ty < 16; ty++)
         for (int tx = 0; tx < 16; tx++)
            for (int r = 0; r < 8; r++) begin
               e.inst = inst; e.is_done = 1'b0;
               e.cyc = s + 1 + (ty * 16 + tx) * p + 1 + l + r;
               e.x = tx * 8; e.y = ty * 8 + r;
               e.bits = solid_of(tile_id(mode, tile_addr(rm, tx, ty))) ? 8'hFF : 8'h00;
               sb_q.push_back(e);
            end
      e.inst = inst; e.is_done = 1'b1; e.cyc = s + 1 + 256 * p;
      e.x = 0; e.y = 0; e.bits = 8'h00;
      sb_q.push_back(e);
   endtask

   task automatic check_map(input logic [4:0] rm, input int mode);
      int bad;
      bad = 0;
      for (int y = 0; y < 128; y++)
         for (int x = 0; x < 128; x++)
            if (map_q[y][x] != solid_of(tile_id(mode, tile_addr(rm, x / 8, y / 8)))) bad++;
      n_vec++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL map_compare room=%0d got %0d wrong pixels need 0", rm, bad);
      end
   endtask

   // Full load; optional mid-load re-start with another room and a start
   // poke during the DONE cycle, both of which must be ignored.
   task automatic run_load(input int inst, input logic [4:0] rm, input int mode,
                           input int repulse, input bit poke_done);
      int s, p;
      p = (inst == 1) ? 12 : 10;
      rom_mode = mode;
      ff_cnt = 0;
      @(posedge clk); #1;
      room_in = rm;
      s = cyc;
      push_expected(inst, rm, mode, s);
      st[inst] = 1'b1;
      for (int k = 0; k < 256 * p + 4; k++) begin
         @(posedge clk); #1;
         st = 2'b00;
         if (repulse != 0 && cyc == s + repulse) begin
            st[inst] = 1'b1;
            room_in = rm ^ 5'h13;
         end
         if (poke_done && cyc == s + 1 + 256 * p) st[inst] = 1'b1;
      end
      st = 2'b00;
      @(posedge clk); #1;
      n_vec++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL missing_outputs room=%0d got %0d pending need 0", rm, sb_q.size());
         sb_q.delete();
      end
      n_vec++;
      if (busy_o[inst] != 1'b0) begin
         n_fail++;
         $display("FAIL busy_after_load room=%0d got %0b need 0", rm, busy_o[inst]);
      end
      check_map(rm, mode);
   endtask

   task automatic chk(input string name, input int got, input int need);
      n_vec++;
      if (got != need) begin
         n_fail++;
         $display("FAIL %s got %0d need %0d", name, got, need);
      end
   endtask

   initial begin
      bit found;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("reset_busy", busy_o[i], 0);
         chk("reset_done", done_o[i], 0);
         chk("reset_wr_en", wen[i], 0);
         chk("reset_wr_xy", {wx[i], wy[i]}, 0);
         chk("reset_wr_bits", wb[i], 0);
         chk("reset_rom_addr", raddr[i], 0);
      end
      rst = 1'b0;

      // Empty room, then a single solid tile at (3,2) in room 5.
      run_load(0, 5'd0, 0, 0, 1'b0);
      chk("all_clear_ff_count", ff_cnt, 0);
      run_load(0, 5'd5, 1, 0, 1'b0);
      chk("single_tile_ff_count", ff_cnt, 8);
      chk("single_tile_px_24_16", map_q[16][24], 1);
      chk("single_tile_px_31_23", map_q[23][31], 1);
      chk("single_tile_px_32_16", map_q[16][32], 0);

      // Pattern rooms; re-start mid-load and start during DONE are ignored.
      run_load(0, 5'd0, 2, 0, 1'b0);
      run_load(0, 5'd24, 2, 1000, 1'b0);
      run_load(0, 5'd31, 2, 0, 1'b1);

      // Reset at tile 100 row 3.
      rom_mode = 2;
      @(posedge clk); #1;
      room_in = 5'd24;
      push_expected(0, 5'd24, 2, cyc);
      st[0] = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 3000 && !found; k++) begin
         @(posedge clk); #1;
         st = 2'b00;
         if (wen[0] && wx[0] == 7'd32 && wy[0] == 7'd51) found = 1'b1;
      end
      chk("reach_tile100_row3", found, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb_q.delete();
      chk("abort_busy", busy_o[0], 0);
      chk("abort_wr_en", wen[0], 0);
      chk("abort_done", done_o[0], 0);
      repeat (5) @(posedge clk);

      // start together with rst: rst wins.
      #1;
      rst = 1'b1; st[0] = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; st[0] = 1'b0;
      chk("rst_vs_start_busy", busy_o[0], 0);
      @(posedge clk); #1;
      chk("rst_vs_start_busy_later", busy_o[0], 0);

      run_load(0, 5'd7, 2, 0, 1'b0);

      // Three-cycle ROM latency.
      run_load(1, 5'd31, 2, 0, 1'b0);
      run_load(1, 5'd5, 1, 0, 1'b0);
      chk("lat3_single_tile_ff_count", ff_cnt, 8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
